// File: rtl/xor_cipher_pkg.sv
// Shared constants for the XOR cipher transmit path: feeder state encoding,
// key length and the key-byte selector.
package xor_cipher_pkg;

  localparam int KEY_LEN = 4;
  localparam int IDX_W   = $clog2(KEY_LEN);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  function automatic logic [7:0] key_byte(input logic [8*KEY_LEN-1:0] key,
                                          input logic [IDX_W-1:0]     idx);
    return key[8*idx +: 8];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read and occupancy count.
// A push while full is taken only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xor_tx_feeder.sv
// Encrypts received bytes with a rotating 4-byte XOR key, queues them and
// hands them one at a time to a UART transmitter.
//
// state  | meaning
// IDLE   | transmitter free; pops the FIFO head into tx_din when one is queued
// LAUNCH | tx_start high for this single cycle
// WAIT   | byte on the line; tx_din held until tx_done_tick
module xor_tx_feeder
  import xor_cipher_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx_done_tick,
  input  logic [7:0]                  rx_data,
  input  logic [8*KEY_LEN-1:0]        key,
  input  logic                        key_restart,
  input  logic                        tx_done_tick,
  output logic                        tx_start,
  output logic [7:0]                  tx_din,
  output logic                        busy,
  output logic [FIFO_AW:0]            fifo_count,
  output logic                        overflow_tick,
  output logic                        overflow_flag
);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] cur_idx;
  logic [7:0]       cipher;
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             drop;

  // A restart coinciding with a byte applies to that byte.
  assign cur_idx = key_restart ? '0 : idx;
  assign cipher  = rx_data ^ key_byte(key, cur_idx);
  assign pop     = (state == ST_IDLE) & ~fifo_empty;
  assign push    = rx_done_tick & (~fifo_full | pop);
  assign drop    = rx_done_tick & fifo_full & ~pop;
  assign busy    = (state != ST_IDLE);

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (cipher),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (rx_done_tick) begin
      idx <= cur_idx + IDX_W'(1);
    end else if (key_restart) begin
      idx <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_tick <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      overflow_tick <= drop;
      if (drop) overflow_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_din   <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_din   <= fifo_head;
            tx_start <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: state <= ST_WAIT;
        ST_WAIT:   if (tx_done_tick) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_tx_feeder.sv
// Directed bench for xor_tx_feeder: a queue-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_xor_tx_feeder;

  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 1 << FIFO_AW;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx_done_tick;
  logic [7:0]       rx_data;
  logic [31:0]      key;
  logic             key_restart;
  logic             tx_done_tick;
  logic             tx_start;
  logic [7:0]       tx_din;
  logic             busy;
  logic [FIFO_AW:0] fifo_count;
  logic             overflow_tick;
  logic             overflow_flag;

  int errors = 0;
  int checks = 0;
  int ovf_seen = 0;
  logic [7:0] captured [8];

  xor_tx_feeder #(.FIFO_AW(FIFO_AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_done_tick  (rx_done_tick),
    .rx_data       (rx_data),
    .key           (key),
    .key_restart   (key_restart),
    .tx_done_tick  (tx_done_tick),
    .tx_start      (tx_start),
    .tx_din        (tx_din),
    .busy          (busy),
    .fifo_count    (fifo_count),
    .overflow_tick (overflow_tick),
    .overflow_flag (overflow_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of ciphertexts, a transmitter phase and a key index.
  logic [7:0] m_q [$];
  int         m_idx;
  int         m_phase;   // 0 free, 1 launching, 2 on the line
  logic [7:0] m_cur;
  logic       m_start;
  logic       m_ovf;
  logic       m_flag;
  int         m_kb;
  logic [7:0] m_c;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_idx = 0; m_phase = 0; m_cur = 8'h00;
      m_start = 0; m_ovf = 0; m_flag = 0;
    end else begin
      m_start = 0;
      m_ovf   = 0;
      if (m_phase == 0 && m_q.size() > 0) begin
        m_cur   = m_q.pop_front();
        m_start = 1;
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && tx_done_tick) begin
        m_phase = 0;
      end
      if (rx_done_tick) begin
        m_kb = key_restart ? 0 : m_idx;
        m_c  = rx_data ^ key[8*m_kb +: 8];
        if (m_q.size() < DEPTH) m_q.push_back(m_c);
        else begin m_ovf = 1; m_flag = 1; end
        m_idx = (m_kb + 1) % 4;
      end else if (key_restart) begin
        m_idx = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("tx_start", tx_start, m_start);
    chk("tx_din", tx_din, m_cur);
    chk("busy", busy, m_phase != 0);
    chk("fifo_count", fifo_count, m_q.size());
    chk("overflow_tick", overflow_tick, m_ovf);
    chk("overflow_flag", overflow_flag, m_flag);
    if (overflow_tick) ovf_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // All driver tasks start and end on a falling edge.
  task automatic rx_byte(input logic [7:0] b, input logic restart);
    rx_data = b; rx_done_tick = 1'b1; key_restart = restart;
    @(negedge clk);
    rx_done_tick = 1'b0; key_restart = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      while (!busy && t < 40) begin @(negedge clk); t++; end
      if (!busy) begin
        chk("serve_timeout", 1, 0);
        return;
      end
      captured[i] = tx_din;
      repeat (2) @(negedge clk);
      pulse_done();
    end
  endtask

  int starts;
  logic [7:0] exp_a [5];
  logic [7:0] exp_c [5];

  initial begin
    exp_a = '{8'h50, 8'h60, 8'h70, 8'h00, 8'h54};
    exp_c = '{8'h10, 8'h20, 8'h4B, 8'h22, 8'h11};
    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; key = 32'h44332211;
    key_restart = 1'b0; tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_din", tx_din, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_flag", overflow_flag, 0);
    reset = 1'b0;
    @(negedge clk);

    // five bytes back to back: one launches, four queue, none dropped
    rx_byte(8'h41, 0); rx_byte(8'h42, 0); rx_byte(8'h43, 0);
    rx_byte(8'h44, 0); rx_byte(8'h45, 0);
    chk("seq_no_ovf", ovf_seen, 0);
    serve(5);
    for (int i = 0; i < 5; i++) chk($sformatf("seq_byte%0d", i), captured[i], exp_a[i]);

    // latency from idle and no relaunch before tx_done_tick
    rx_byte(8'h10, 0);
    chk("lat_cycle1", tx_start, 0);
    @(negedge clk);
    chk("lat_cycle2", tx_start, 1);
    starts = 0;
    repeat (10) begin @(negedge clk); if (tx_start) starts++; end
    chk("no_relaunch", starts, 0);
    chk("held_busy", busy, 1);
    pulse_done();
    repeat (2) @(negedge clk);
    pulse_done();
    repeat (2) @(negedge clk);
    chk("idle_done_ignored", busy, 0);

    // key_restart handling, alone and coinciding with a byte
    key_restart = 1'b1; @(negedge clk); key_restart = 1'b0;
    rx_byte(8'h01, 0); rx_byte(8'h02, 0);
    key_restart = 1'b1; @(negedge clk); key_restart = 1'b0;
    rx_byte(8'h5A, 0);
    rx_byte(8'h33, 1); rx_byte(8'h33, 0);
    serve(5);
    for (int i = 0; i < 5; i++) chk($sformatf("restart_byte%0d", i), captured[i], exp_c[i]);

    // six bytes with the transmitter stalled: one dropped
    for (int i = 0; i < 6; i++) rx_byte(8'h60 + 8'(i), 0);
    repeat (3) @(negedge clk);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow_flag, 1);
    chk("ovf_ticks", ovf_seen, 1);
    chk("ovf_busy", busy, 1);

    // full FIFO, byte arrives on the cycle of the pop
    pulse_done();
    rx_byte(8'h77, 0);
    chk("pushpop_count", fifo_count, 4);
    chk("pushpop_no_ovf", ovf_seen, 1);
    serve(5);
    chk("drained", fifo_count, 0);
    chk("flag_sticky", overflow_flag, 1);

    // reset mid-byte with three queued
    for (int i = 0; i < 4; i++) rx_byte(8'hA0 + 8'(i), 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_count", fifo_count, 3);
    #2 reset = 1'b1;
    #1;
    chk("async_tx_start", tx_start, 0);
    chk("async_tx_din", tx_din, 8'h00);
    chk("async_busy", busy, 0);
    chk("async_count", fifo_count, 0);
    chk("async_ovf_tick", overflow_tick, 0);
    chk("async_flag", overflow_flag, 0);
    @(negedge clk);
    reset = 1'b0;
    starts = 0;
    repeat (20) begin @(negedge clk); if (tx_start) starts++; end
    chk("post_rst_quiet", starts, 0);
    chk("post_rst_count", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
